// File: rtl/subtractor_32bit_seq_if.sv
// Start/busy/done handshake and operand/result bundle for subtractor_32bit_seq.
interface subtractor_32bit_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             overflow;
    logic             zero;
    logic             neg;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, overflow, zero, neg
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, overflow, zero, neg
    );
endinterface

// File: rtl/subtractor_32bit_seq.sv
// Multi-cycle a - b - bin, one SLICE_W slice per cycle, LSB slice first.
// Optional zero/neg result flags are built only when SUB_FLAGS_EN is defined.
module subtractor_32bit_seq #(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 16
) (
    input logic                   clock,
    input logic                   reset,
    subtractor_32bit_seq_if.slave s
);
    localparam int N  = WIDTH / SLICE_W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q, b_q, diff_q, diff_nxt;
    logic             brw_q;
    logic             busy_q, done_q, bout_q, ovf_q;
    logic             accept, last;
    logic [SLICE_W-1:0] a_sl, b_sl;
    logic [SLICE_W:0]   sub;
    int                 off;

    // FSM: accept only from IDLE, so a start while busy is simply dropped
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: if (s.start) begin
                accept  = 1'b1;
                state_d = RUN;
            end
            RUN: if (idx_q == IW'(N - 1)) begin
                last    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // One slice of the subtract; the extra top bit is the borrow out of the slice
    always_comb begin
        off      = int'(idx_q) * SLICE_W;
        a_sl     = a_q[off +: SLICE_W];
        b_sl     = b_q[off +: SLICE_W];
        sub      = {1'b0, a_sl} - {1'b0, b_sl} - (SLICE_W+1)'(brw_q);
        diff_nxt = diff_q;
        diff_nxt[off +: SLICE_W] = sub[SLICE_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            brw_q  <= 1'b0;
            idx_q  <= '0;
            diff_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q    <= s.a;
                b_q    <= s.b;
                brw_q  <= s.bin;
                idx_q  <= '0;
                diff_q <= '0;
                busy_q <= 1'b1;
                bout_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else if (state_q == RUN) begin
                diff_q <= diff_nxt;
                brw_q  <= sub[SLICE_W];
                idx_q  <= idx_q + 1'b1;
                if (last) begin
                    idx_q  <= '0;
                    bout_q <= sub[SLICE_W];
                    // Signed overflow: operand signs differ and result sign differs from a
                    ovf_q  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sub[SLICE_W-1] ^ a_q[WIDTH-1]);
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign s.busy     = busy_q;
    assign s.done     = done_q;
    assign s.diff     = diff_q;
    assign s.bout     = bout_q;
    assign s.overflow = ovf_q;

`ifdef SUB_FLAGS_EN
    logic zero_q, neg_q;

    always_ff @(posedge clock) begin
        if (reset || accept) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (last) begin
            zero_q <= (diff_nxt == '0);
            neg_q  <= sub[SLICE_W-1];
        end
    end

    assign s.zero = zero_q;
    assign s.neg  = neg_q;
`else
    assign s.zero = 1'b0;
    assign s.neg  = 1'b0;
`endif

endmodule

// File: tb/tb_subtractor_32bit_seq.sv
// Randomized and directed bench for subtractor_32bit_seq against an arithmetic reference model.
module tb_subtractor_32bit_seq;
    localparam int WIDTH   = 32;
    localparam int SLICE_W = 16;
    localparam int N       = WIDTH / SLICE_W;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    subtractor_32bit_seq_if #(.WIDTH(WIDTH)) bus ();

    subtractor_32bit_seq #(.WIDTH(WIDTH), .SLICE_W(SLICE_W)) dut (
        .clock (clock),
        .reset (reset),
        .s     (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Reference: plain unsigned and signed arithmetic on whole words
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                         output logic [31:0] d, output logic bo, output logic ov,
                         output logic z, output logic ng);
        longint sd;
        d  = a - b - {31'd0, bin};
        bo = (longint'(a) < longint'(b) + longint'(bin));
        sd = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
`ifdef SUB_FLAGS_EN
        z  = (d == 32'd0);
        ng = (sd < 0) ^ ov;
`else
        z  = 1'b0;
        ng = 1'b0;
`endif
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                          input string name, input bit scramble);
        logic [31:0] ed;
        logic eb, eo, ez, en;
        int n;
        model(a, b, bin, ed, eb, eo, ez, en);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.bin = bin;
        tick;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.diff !== 32'd0)
            begin failures++; $display("FAIL %s accept: busy=%b done=%b diff=%h expected 1 0 0", name, bus.busy, bus.done, bus.diff); end
        bus.start = 1'b0;
        if (scramble) begin bus.a = $urandom; bus.b = $urandom; bus.bin = 1'($urandom); end
        n = 0;
        do begin tick; n++; end while (bus.done !== 1'b1 && n < 8);
        checks++;
        if (n != N) begin failures++; $display("FAIL %s latency: got %0d edges expected %0d", name, n, N); end
        checks++;
        if (bus.diff !== ed) begin failures++; $display("FAIL %s diff: got %h expected %h", name, bus.diff, ed); end
        checks++;
        if (bus.bout !== eb || bus.overflow !== eo)
            begin failures++; $display("FAIL %s bout/ovf: got %b/%b expected %b/%b", name, bus.bout, bus.overflow, eb, eo); end
        checks++;
        if (bus.zero !== ez || bus.neg !== en || bus.busy !== 1'b0)
            begin failures++; $display("FAIL %s flags: zero=%b neg=%b busy=%b expected %b %b 0", name, bus.zero, bus.neg, bus.busy, ez, en); end
        tick;
        checks++;
        if (bus.done !== 1'b0 || bus.diff !== ed)
            begin failures++; $display("FAIL %s hold: done=%b diff=%h expected 0 %h", name, bus.done, bus.diff, ed); end
    endtask

    task automatic test_reset;
        bus.start = 1'b1; bus.a = 32'h1234_5678; bus.b = 32'h1; bus.bin = 1'b0;
        reset = 1'b1;
        tick; tick;
        checks++;
        if ({bus.busy, bus.done, bus.bout, bus.overflow, bus.zero, bus.neg} !== 6'b0 || bus.diff !== 32'd0)
            begin failures++; $display("FAIL reset: busy=%b done=%b diff=%h bout=%b ovf=%b expected all 0", bus.busy, bus.done, bus.diff, bus.bout, bus.overflow); end
        bus.start = 1'b0;
        reset = 1'b0;
        tick;
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset idle: busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_directed;
        run_op(32'h0001_0000, 32'h0000_0001, 1'b0, "cross_slice", 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, "underflow", 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, "signed_ovf", 1'b0);
        run_op(32'h0000_0005, 32'h0000_0005, 1'b1, "borrow_in", 1'b0);
        run_op(32'h0000_0005, 32'h0000_0005, 1'b0, "equal", 1'b0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, "pos_minus_neg", 1'b0);
        run_op(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, "max_borrow", 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++)
            run_op($urandom, $urandom, 1'($urandom), "random", 1'b1);
    endtask

    task automatic test_ignore_start;
        logic [31:0] ed;
        logic eb, eo, ez, en;
        model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, ed, eb, eo, ez, en);
        bus.start = 1'b1; bus.a = 32'hDEAD_BEEF; bus.b = 32'h0BAD_F00D; bus.bin = 1'b1;
        tick;
        bus.a = 32'h1111_1111; bus.b = 32'h2222_2222; bus.bin = 1'b0;
        tick;
        bus.start = 1'b0;
        tick;
        checks++;
        if (bus.done !== 1'b1 || bus.diff !== ed || bus.bout !== eb)
            begin failures++; $display("FAIL ignore_start: done=%b diff=%h bout=%b expected 1 %h %b", bus.done, bus.diff, bus.bout, ed, eb); end
        tick;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== ed)
            begin failures++; $display("FAIL ignore_queued: busy=%b done=%b diff=%h expected 0 0 %h", bus.busy, bus.done, bus.diff, ed); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d1, d2, a2, b2;
        logic eb, eo, ez, en, bin2;
        logic [31:0] a1, b1;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom; bin2 = 1'($urandom);
        model(a1, b1, 1'b0, d1, eb, eo, ez, en);
        model(a2, b2, bin2, d2, eb, eo, ez, en);
        bus.start = 1'b1; bus.a = a1; bus.b = b1; bus.bin = 1'b0;
        tick;
        tick;
        bus.a = a2; bus.b = b2; bus.bin = bin2;
        tick;
        checks++;
        if (bus.done !== 1'b1 || bus.diff !== d1)
            begin failures++; $display("FAIL b2b first: done=%b diff=%h expected 1 %h", bus.done, bus.diff, d1); end
        tick;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.diff !== 32'd0)
            begin failures++; $display("FAIL b2b accept: busy=%b done=%b diff=%h expected 1 0 0", bus.busy, bus.done, bus.diff); end
        bus.start = 1'b0;
        tick;
        tick;
        checks++;
        if (bus.done !== 1'b1 || bus.diff !== d2 || bus.bout !== eb || bus.overflow !== eo)
            begin failures++; $display("FAIL b2b second: done=%b diff=%h bout=%b ovf=%b expected 1 %h %b %b", bus.done, bus.diff, bus.bout, bus.overflow, d2, eb, eo); end
        tick;
    endtask

    task automatic test_reset_mid;
        int seen;
        bus.start = 1'b1; bus.a = 32'h0001_0000; bus.b = 32'h1; bus.bin = 1'b0;
        tick;
        bus.start = 1'b0;
        reset = 1'b1;
        tick;
        checks++;
        if (bus.busy !== 1'b0 || bus.diff !== 32'd0 || bus.done !== 1'b0)
            begin failures++; $display("FAIL reset_mid: busy=%b diff=%h done=%b expected 0 0 0", bus.busy, bus.diff, bus.done); end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin tick; if (bus.done === 1'b1) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL reset_mid no_done: got %0d pulses expected 0", seen); end
        run_op(32'hCAFE_0000, 32'h0000_BABE, 1'b1, "after_reset", 1'b0);
    endtask

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        test_reset;
        test_directed;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
